// File: rtl/athena_pkg.sv
// Shared types and helpers for the Athena ROM loader: loader state, widths and
// big-endian byte-lane selection.
package athena_pkg;

    localparam int unsigned GAME_W     = 8;
    localparam int unsigned ADDR_W_DEF = 25;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StEmit,
        StHold,
        StRun
    } loader_state_e;

    // Lane 0 is the most significant byte of the word.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        unique case (lane)
            2'd0: b = word[31:24];
            2'd1: b = word[23:16];
            2'd2: b = word[15:8];
            2'd3: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/athena_byte_serializer.sv
// Turns one captured 32-bit word into four paced ioctl byte writes, WR_GAP idle
// cycles after every strobe; abort stops the sequence immediately.
module athena_byte_serializer
    import athena_pkg::*;
#(
    parameter int unsigned WR_GAP = 3,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic [ADDR_W-1:0] ioctl_addr_o,
    output logic [7:0]        ioctl_data_o,
    output logic              ioctl_wr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              strobe_o
);

    localparam int unsigned GapW = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;

    logic              busy_q;
    logic [2:0]        sent_q;
    logic [GapW-1:0]   gap_q;
    logic [31:0]       word_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [ADDR_W-1:0] ioctl_addr_q;
    logic [7:0]        ioctl_data_q;

    logic gap_zero;
    logic emit_next;
    logic last_done;

    always_comb begin
        gap_zero  = (gap_q == '0);
        emit_next = busy_q && gap_zero && (sent_q != 3'd4);
        // Done fires in the final gap cycle so the next word can be taken right after.
        last_done = busy_q && gap_zero && (sent_q == 3'd4);
        done_o    = last_done && !abort_i;
        strobe_o  = !abort_i && (start_i || emit_next);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q       <= 1'b0;
            sent_q       <= 3'd0;
            gap_q        <= '0;
            word_q       <= '0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            ioctl_addr_q <= '0;
            ioctl_data_q <= '0;
        end else begin
            wr_q <= 1'b0;
            if (abort_i) begin
                busy_q <= 1'b0;
            end else if (start_i) begin
                busy_q       <= 1'b1;
                word_q       <= data_i;
                addr_q       <= addr_i;
                sent_q       <= 3'd1;
                gap_q        <= GapW'(WR_GAP);
                wr_q         <= 1'b1;
                ioctl_addr_q <= addr_i;
                ioctl_data_q <= byte_lane(data_i, 2'd0);
            end else if (busy_q) begin
                if (!gap_zero) begin
                    gap_q <= gap_q - GapW'(1);
                end else if (sent_q == 3'd4) begin
                    busy_q <= 1'b0;
                end else begin
                    wr_q         <= 1'b1;
                    ioctl_addr_q <= addr_q + ADDR_W'(sent_q);
                    ioctl_data_q <= byte_lane(word_q, sent_q[1:0]);
                    sent_q       <= sent_q + 3'd1;
                    gap_q        <= GapW'(WR_GAP);
                end
            end
        end
    end

    assign ioctl_addr_o = ioctl_addr_q;
    assign ioctl_data_o = ioctl_data_q;
    assign ioctl_wr_o   = wr_q;
    assign busy_o       = busy_q;

endmodule

// File: rtl/athena_rom_loader.sv
// ROM download sequencer for AthenaCore: accepts words, feeds the byte serializer,
// owns core reset across the load and a fixed settle time afterwards.
module athena_rom_loader
    import athena_pkg::*;
#(
    parameter int unsigned WR_GAP     = 3,
    parameter int unsigned RESET_HOLD = 1024,
    parameter int unsigned ADDR_W     = ADDR_W_DEF
) (
    input  logic              clk_53_6_mhz,
    input  logic              reset_n,
    input  logic              load_start,
    input  logic              load_done,
    input  logic [GAME_W-1:0] game_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [31:0]       wr_addr,
    input  logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [7:0]        ioctl_data,
    output logic              ioctl_wr,
    output logic              core_reset_n,
    output logic [GAME_W-1:0] game,
    output logic              loading,
    output logic [ADDR_W:0]   byte_count
);

    localparam int unsigned HoldW = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;

    loader_state_e     state_q;
    logic              wr_ready_q;
    logic              core_reset_n_q;
    logic [GAME_W-1:0] game_q;
    logic              loading_q;
    logic [ADDR_W:0]   byte_count_q;
    logic              pending_done_q;
    logic [HoldW-1:0]  hold_cnt_q;

    logic              ser_start;
    logic              ser_busy;
    logic              ser_done;
    logic              ser_strobe;
    logic [ADDR_W-1:0] word_addr;
    logic              unused_bits;

    assign ser_start   = (state_q == StLoad) && wr_valid && wr_ready_q && !load_start;
    assign word_addr   = {wr_addr[ADDR_W-1:2], 2'b00};
    assign unused_bits = ^{wr_addr[1:0], wr_addr[31:ADDR_W], ser_busy};

    athena_byte_serializer #(
        .WR_GAP (WR_GAP),
        .ADDR_W (ADDR_W)
    ) u_serializer (
        .clk_i        (clk_53_6_mhz),
        .rst_ni       (reset_n),
        .start_i      (ser_start),
        .abort_i      (load_start),
        .addr_i       (word_addr),
        .data_i       (wr_data),
        .ioctl_addr_o (ioctl_addr),
        .ioctl_data_o (ioctl_data),
        .ioctl_wr_o   (ioctl_wr),
        .busy_o       (ser_busy),
        .done_o       (ser_done),
        .strobe_o     (ser_strobe)
    );

    always_ff @(posedge clk_53_6_mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            wr_ready_q     <= 1'b0;
            core_reset_n_q <= 1'b0;
            game_q         <= '0;
            loading_q      <= 1'b0;
            byte_count_q   <= '0;
            pending_done_q <= 1'b0;
            hold_cnt_q     <= '0;
        end else if (load_start) begin
            // Restart from any state; load_start outranks a coincident load_done.
            state_q        <= StLoad;
            wr_ready_q     <= 1'b1;
            core_reset_n_q <= 1'b0;
            game_q         <= game_in;
            loading_q      <= 1'b1;
            byte_count_q   <= '0;
            pending_done_q <= 1'b0;
        end else begin
            if (ser_strobe && byte_count_q != '1) begin
                byte_count_q <= byte_count_q + (ADDR_W + 1)'(1);
            end
            case (state_q)
                StLoad: begin
                    if (ser_start) begin
                        state_q        <= StEmit;
                        wr_ready_q     <= 1'b0;
                        pending_done_q <= load_done;
                    end else if (load_done) begin
                        state_q    <= StHold;
                        wr_ready_q <= 1'b0;
                        hold_cnt_q <= '0;
                    end
                end
                StEmit: begin
                    if (load_done) begin
                        pending_done_q <= 1'b1;
                    end
                    if (ser_done) begin
                        if (pending_done_q || load_done) begin
                            state_q    <= StHold;
                            hold_cnt_q <= '0;
                        end else begin
                            state_q    <= StLoad;
                            wr_ready_q <= 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (hold_cnt_q == HoldW'(RESET_HOLD - 1)) begin
                        state_q        <= StRun;
                        core_reset_n_q <= 1'b1;
                        loading_q      <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HoldW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_ready     = wr_ready_q;
    assign core_reset_n = core_reset_n_q;
    assign game         = game_q;
    assign loading      = loading_q;
    assign byte_count   = byte_count_q;

endmodule

// File: tb/tb_athena_rom_loader.sv
// Directed self-checking bench for athena_rom_loader with default parameters.
module tb_athena_rom_loader;

    logic        clk_53_6_mhz = 1'b0;
    logic        reset_n;
    logic        load_start;
    logic        load_done;
    logic [7:0]  game_in;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        core_reset_n;
    logic [7:0]  game;
    logic        loading;
    logic [25:0] byte_count;

    int checks = 0;
    int errors = 0;

    always #5 clk_53_6_mhz = ~clk_53_6_mhz;

    athena_rom_loader dut (
        .clk_53_6_mhz (clk_53_6_mhz),
        .reset_n      (reset_n),
        .load_start   (load_start),
        .load_done    (load_done),
        .game_in      (game_in),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .ioctl_addr   (ioctl_addr),
        .ioctl_data   (ioctl_data),
        .ioctl_wr     (ioctl_wr),
        .core_reset_n (core_reset_n),
        .game         (game),
        .loading      (loading),
        .byte_count   (byte_count)
    );

    // Advance one cycle; inputs set after this apply to the new cycle.
    task automatic step();
        @(posedge clk_53_6_mhz);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; load_start = 0; load_done = 0; game_in = 0;
        wr_valid = 0; wr_addr = 0; wr_data = 0;
        #23;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
        checks++; if (ioctl_wr !== 1'b0) begin errors++; $display("FAIL reset_ioctl_wr got %b want 0", ioctl_wr); end
        checks++; if (ioctl_addr !== 25'h0) begin errors++; $display("FAIL reset_ioctl_addr got %h want 0", ioctl_addr); end
        checks++; if (ioctl_data !== 8'h0) begin errors++; $display("FAIL reset_ioctl_data got %h want 0", ioctl_data); end
        checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL reset_core_reset_n got %b want 0", core_reset_n); end
        checks++; if (game !== 8'h0) begin errors++; $display("FAIL reset_game got %h want 0", game); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL reset_loading got %b want 0", loading); end
        checks++; if (byte_count !== 26'h0) begin errors++; $display("FAIL reset_byte_count got %0d want 0", byte_count); end
        reset_n = 1'b1;
        step(); step();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL idle_wr_ready got %b want 0", wr_ready); end
    endtask

    task automatic test_load_start();
        load_start = 1'b1; game_in = 8'h03;
        step();
        load_start = 1'b0; game_in = 8'h00;
        checks++; if (game !== 8'h03) begin errors++; $display("FAIL start_game got %h want 03", game); end
        checks++; if (loading !== 1'b1) begin errors++; $display("FAIL start_loading got %b want 1", loading); end
        checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL start_core_reset_n got %b want 0", core_reset_n); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL start_wr_ready got %b want 1", wr_ready); end
    endtask

    // Offer one word in the current cycle T and follow cycles T+1..T+16; optionally
    // pulse load_done at offset done_at (-1 = never). Returns at T+17.
    task automatic do_word(input logic [31:0] a, input logic [31:0] d, input logic [24:0] base,
                           input logic [25:0] cnt_after, input int done_at);
        logic [24:0] ea;
        logic [7:0]  ed;
        logic        exp_wr;
        int          k;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL word_ready_T got %b want 1", wr_ready); end
        wr_addr = a; wr_data = d; wr_valid = 1'b1;
        load_done = (done_at == 0);
        step();
        wr_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            load_done = (c == done_at);
            exp_wr = ((c % 4) == 1);
            checks++;
            if (ioctl_wr !== exp_wr) begin
                errors++; $display("FAIL word_strobe T+%0d got %b want %b", c, ioctl_wr, exp_wr);
            end
            if (exp_wr) begin
                k  = (c - 1) / 4;
                ea = base + 25'(k);
                ed = d[31 - 8*k -: 8];
                checks++; if (ioctl_addr !== ea) begin errors++; $display("FAIL word_addr T+%0d got %h want %h", c, ioctl_addr, ea); end
                checks++; if (ioctl_data !== ed) begin errors++; $display("FAIL word_data T+%0d got %h want %h", c, ioctl_data, ed); end
            end
            checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL word_busy_ready T+%0d got %b want 0", c, wr_ready); end
            step();
        end
        load_done = 1'b0;
        checks++; if (byte_count !== cnt_after) begin errors++; $display("FAIL word_byte_count got %0d want %0d", byte_count, cnt_after); end
    endtask

    task automatic test_single_word();
        do_word(32'h0000_1006, 32'hDEAD_BEEF, 25'h000_1004, 26'd4, -1);
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready_T17 got %b want 1", wr_ready); end
    endtask

    task automatic test_done_mid_emit();
        do_word(32'h0000_2000, 32'h1122_3344, 25'h000_2000, 26'd8, 2);
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL hold_wr_ready got %b want 0", wr_ready); end
        checks++; if (loading !== 1'b1) begin errors++; $display("FAIL hold_loading got %b want 1", loading); end
        for (int i = 0; i < 1023; i++) step();
        checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL hold_last_cycle core_reset_n got %b want 0", core_reset_n); end
        step();
        checks++; if (core_reset_n !== 1'b1) begin errors++; $display("FAIL run_core_reset_n got %b want 1", core_reset_n); end
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL run_loading got %b want 0", loading); end
    endtask

    task automatic test_run_ignores();
        wr_valid = 1'b1; wr_addr = 32'h0000_4000; wr_data = 32'hCAFE_F00D; load_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL run_wr_ready got %b want 0", wr_ready); end
            checks++; if (ioctl_wr !== 1'b0) begin errors++; $display("FAIL run_ioctl_wr got %b want 0", ioctl_wr); end
        end
        wr_valid = 1'b0; load_done = 1'b0;
        checks++; if (core_reset_n !== 1'b1) begin errors++; $display("FAIL run_done_ignored got %b want 1", core_reset_n); end
        checks++; if (byte_count !== 26'd8) begin errors++; $display("FAIL run_byte_count got %0d want 8", byte_count); end
    endtask

    task automatic test_start_done_same();
        load_start = 1'b1; load_done = 1'b1; game_in = 8'h05;
        step();
        load_start = 1'b0; load_done = 1'b0;
        checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL both_core_reset_n got %b want 0", core_reset_n); end
        checks++; if (byte_count !== 26'd0) begin errors++; $display("FAIL both_byte_count got %0d want 0", byte_count); end
        checks++; if (game !== 8'h05) begin errors++; $display("FAIL both_game got %h want 05", game); end
        checks++; if (loading !== 1'b1) begin errors++; $display("FAIL both_loading got %b want 1", loading); end
        step();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL both_stays_load got %b want 1", wr_ready); end
    endtask

    task automatic test_abort_mid_emit();
        int strobes;
        wr_addr = 32'h0000_3000; wr_data = 32'hAABB_CCDD; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        checks++; if (ioctl_wr !== 1'b1) begin errors++; $display("FAIL abort_first_strobe got %b want 1", ioctl_wr); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (ioctl_wr !== 1'b1) begin errors++; $display("FAIL abort_second_strobe got %b want 1", ioctl_wr); end
        checks++; if (byte_count !== 26'd2) begin errors++; $display("FAIL abort_mid_count got %0d want 2", byte_count); end
        step();
        load_start = 1'b1; game_in = 8'h07;
        step();
        load_start = 1'b0;
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL abort_wr_ready got %b want 1", wr_ready); end
        checks++; if (byte_count !== 26'd0) begin errors++; $display("FAIL abort_byte_count got %0d want 0", byte_count); end
        checks++; if (game !== 8'h07) begin errors++; $display("FAIL abort_game got %h want 07", game); end
        strobes = 0;
        for (int i = 0; i < 12; i++) begin
            if (ioctl_wr === 1'b1) strobes++;
            step();
        end
        checks++; if (strobes != 0) begin errors++; $display("FAIL abort_no_more_strobes got %0d want 0", strobes); end
    endtask

    task automatic test_wrap();
        do_word(32'h01FF_FFFC, 32'h0102_0304, 25'h1FF_FFFC, 26'd4, -1);
        do_word(32'h0200_0000, 32'h0506_0708, 25'h000_0000, 26'd8, -1);
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL wrap_ready got %b want 1", wr_ready); end
    endtask

    task automatic test_async_reset_hold();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        step(); step();
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL pre_reset_wr_ready got %b want 0", wr_ready); end
        checks++; if (loading !== 1'b1) begin errors++; $display("FAIL pre_reset_loading got %b want 1", loading); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (loading !== 1'b0) begin errors++; $display("FAIL async_loading got %b want 0", loading); end
        checks++; if (game !== 8'h0) begin errors++; $display("FAIL async_game got %h want 0", game); end
        checks++; if (byte_count !== 26'h0) begin errors++; $display("FAIL async_byte_count got %0d want 0", byte_count); end
        checks++; if (core_reset_n !== 1'b0) begin errors++; $display("FAIL async_core_reset_n got %b want 0", core_reset_n); end
        checks++; if (ioctl_addr !== 25'h0) begin errors++; $display("FAIL async_ioctl_addr got %h want 0", ioctl_addr); end
        checks++; if (ioctl_data !== 8'h0) begin errors++; $display("FAIL async_ioctl_data got %h want 0", ioctl_data); end
        checks++; if (ioctl_wr !== 1'b0) begin errors++; $display("FAIL async_ioctl_wr got %b want 0", ioctl_wr); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL async_wr_ready got %b want 0", wr_ready); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_load_start();
        test_single_word();
        test_done_mid_emit();
        test_run_ignores();
        test_start_done_same();
        test_abort_mid_emit();
        test_wrap();
        test_async_reset_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/athena_rom_loader.md
Name: athena_rom_loader

Overview:
- Sequences ROM download into AthenaCore's ioctl byte-write port and owns the core's reset during load.
- Accepts 32-bit word writes already crossed into the 53.6 MHz core domain.
- Serialises each word into four paced ioctl byte writes.
- Holds the core in reset from load start until a fixed settle time after load done.
- Latches the game select. Sits between the bridge ROM write path and AthenaCore inside athena_top.

Parameters:
- WR_GAP, 3: idle cycles between consecutive ioctl_wr pulses (≥0).
- RESET_HOLD, 1024: cycles core_reset_n stays low after the last byte is written (≥1).
- ADDR_W, 25: ioctl address width.

Ports:
- clk_53_6_mhz  in  1  core clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_start  in  1  one-cycle pulse: begin a ROM load.
- load_done  in  1  one-cycle pulse: host has sent all words.
- game_in  in  8  game select; sampled on load_start.
- wr_valid  in  1  word write offered.
- wr_ready  out  1  word write accepted when wr_valid & wr_ready.
- wr_addr  in  32  byte address of word.
- wr_data  in  32  word, big-endian byte order.
- ioctl_addr  out  ADDR_W  byte address to core.
- ioctl_data  out  8  byte to core.
- ioctl_wr  out  1  one-cycle write strobe to core.
- core_reset_n  out  1  drives AthenaCore RESETn/VIDEO_RSTn.
- game  out  8  latched game select to core GAME.
- loading  out  1  high in LOAD, EMIT and HOLD.
- byte_count  out  ADDR_W+1  bytes written since last load_start.

Behaviour:
- Reset values:
  - wr_ready=0, ioctl_wr=0, ioctl_addr=0, ioctl_data=0.
  - core_reset_n=0 (core never runs without ROM), game=0, loading=0, byte_count=0, state IDLE.
- States: IDLE, LOAD, EMIT, HOLD, RUN.
- IDLE:
  - wr_ready=0; core_reset_n=0.
  - load_start → LOAD.
- Any state, on load_start:
  - Go to LOAD next cycle.
  - Latch game=game_in; clear byte_count.
  - core_reset_n=0; abort any in-progress EMIT; ioctl_wr=0 from the next cycle.
  - load_start beats load_done when both arrive in the same cycle.
- LOAD:
  - wr_ready=1.
  - Handshake in cycle T: capture word A=wr_addr with A[1:0] forced to 0 and bits above ADDR_W-1 truncated; capture D=wr_data; go to EMIT; wr_ready=0 from T+1.
  - load_done with no handshake that cycle → HOLD.
- EMIT:
  - Byte k (k=0..3) strobes at cycle T+1+k*(WR_GAP+1).
  - Per strobe: ioctl_wr=1 for exactly one cycle; ioctl_addr=A+k; ioctl_data=D[31-8k -: 8]; byte_count+=1 that cycle.
  - ioctl_addr/ioctl_data hold their values between strobes.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - After byte 3 plus WR_GAP idle cycles, return to LOAD: wr_ready=1 at T+4*(WR_GAP+1)+1. With WR_GAP=3, the next word is accepted at the earliest at T+17.
  - If pending_done is set, go to HOLD instead.
- load_done arriving during EMIT, or in the handshake cycle itself:
  - Set pending_done.
  - The current word completes all 4 bytes before HOLD is entered.
- HOLD:
  - core_reset_n=0; counter runs RESET_HOLD cycles; then RUN.
- RUN:
  - core_reset_n=1, loading=0, wr_ready=0.
  - wr_valid is ignored and the handshake never completes.
  - load_done is ignored.
- load_done in IDLE or RUN: ignored.
- byte_count saturates at all-ones.
- Async reset mid-load: everything returns to reset values immediately. A partially written word is not resumed.

Decomposition:
- athena_pkg:
  - loader state enum.
  - GAME_W=8, ADDR_W default, byte-lane select function (big-endian).
- Sub-module athena_byte_serializer:
  - Takes a captured word/address plus a start pulse.
  - Produces the 4 paced ioctl strobes, a busy flag and a done pulse.
  - Parameter WR_GAP; abort input driven by load_start.
- Top module holds the state machine, HOLD counter, game latch and byte_count.

Test Plan:
- Reset then load_start (game_in=8'h03) → game=03, loading=1, core_reset_n=0, wr_ready=1 next cycle.
- Word wr_addr=32'h0000_1006, wr_data=32'hDEAD_BEEF, WR_GAP=3:
  - Strobes at T+1, T+5, T+9, T+13 with addr 1004,1005,1006,1007 and data DE,AD,BE,EF.
  - wr_ready high again at T+17; byte_count=4.
- load_done pulsed at T+2 during EMIT:
  - All 4 bytes still written, then HOLD.
  - core_reset_n rises exactly RESET_HOLD cycles after the trailing gap of the last byte; loading=0.
- load_start and load_done in the same cycle in RUN → LOAD entered, core_reset_n=0, byte_count=0.
- load_start at T+6 mid-EMIT → no further ioctl_wr after T+6, LOAD with wr_ready=1 at T+7.
- wr_addr=32'h01FF_FFFC:
  - Bytes at 1FFFFFC..1FFFFFF.
  - Next word at 32'h0200_0000 → ioctl_addr wraps to 0.
- Async reset_n low mid-HOLD → all outputs at reset values in the same cycle, no clock edge required.
